motion_cmd_parser: RTL and testbench

//  Parametrised successor to the per-letter traction message detectors. Consumes the UART RX byte

---
 rtl/motion_cmd_parser_pkg.sv | 27 ++
 rtl/motion_cmd_parser_watchdog.sv | 31 +++
 rtl/motion_cmd_parser.sv | 178 +++++++++++++++++
 tb/tb_motion_cmd_parser.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/motion_cmd_parser_pkg.sv
// Shared constants for the framed motion-command protocol: framing bytes,
// direction codes, parser state encoding and the frame checksum.
`timescale 1ns/1ps
package robocol_cmd_pkg;

    localparam logic [6:0] START_BYTE = 7'h23;
    localparam logic [6:0] DIR_FWD    = 7'h2B;
    localparam logic [6:0] DIR_REV    = 7'h2D;
    localparam logic [6:0] DIR_STOP   = 7'h30;
    localparam logic [7:0] ID_ALL_DEF = 8'h2A;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_ID  = 3'd1,
        ST_GET_DIR = 3'd2,
        ST_GET_MAG = 3'd3,
        ST_GET_CHK = 3'd4,
        ST_APPLY   = 3'd5
    } cmd_state_e;

    function automatic logic [6:0] cmd_chk(input logic [6:0] id,
                                           input logic [6:0] dir,
                                           input logic [6:0] mag);
        return id ^ dir ^ mag;
    endfunction

endpackage

// File: rtl/motion_cmd_parser_watchdog.sv
// Per-channel command watchdog: reloads on kick, counts down otherwise,
// and reports expiry while the count sits at zero.
`timescale 1ns/1ps
module cmd_watchdog #(
    parameter int unsigned WDT_CYC = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick,
    output logic expired
);
    localparam int CW = $clog2(WDT_CYC + 1);

    logic [CW-1:0] cnt_r;

    // Countdown; a kick on the expiry cycle wins and reloads the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (kick) begin
            cnt_r <= CW'(WDT_CYC);
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == '0);

endmodule

// File: rtl/motion_cmd_parser.sv
// Parses '#',ID,DIR,MAG,CHK frames from the UART byte stream into signed
// per-channel setpoints, with inter-byte timeout and per-channel watchdogs.
`timescale 1ns/1ps
module motion_cmd_parser
    import robocol_cmd_pkg::*;
#(
    parameter int                  NCH     = 6,
    parameter int                  MAG_W   = 7,
    // Byte k (LSB first) is channel k's ID: channel 0 = 'L', 1 = 'R', ...
    parameter logic [NCH*8-1:0]    CH_IDS  = "DCBARL",
    parameter logic [7:0]          ID_ALL  = ID_ALL_DEF,
    parameter logic [MAG_W-1:0]    MAX_MAG = 7'd100,
    parameter int unsigned         WDT_CYC = 25_000_000,
    parameter int unsigned         BYTE_TO = 500_000
) (
    input  logic                         FPGA_CLK1_50,
    input  logic                         RESET_N,
    input  logic                         rx_ready,
    input  logic [7:0]                   rx_data,
    output logic                         rx_clear,
    output logic [NCH*(MAG_W+1)-1:0]     setpoint,
    output logic [NCH-1:0]               sp_update,
    output logic [NCH-1:0]               sp_stale,
    output logic [7:0]                   err_count
);
    localparam int SP_W = MAG_W + 1;
    localparam int TW   = $clog2(BYTE_TO + 1);

    cmd_state_e        state_r, state_nx;
    logic              clr_prev_r, take, unused_rx_msb;
    logic [6:0]        rx7, id_r, dir_r, mag_r;
    logic [NCH-1:0]    id_match, id_mask, mask_r, expired;
    logic              id_hit, is_all, fsm_err, byte_to_err, do_apply;
    logic [TW-1:0]     tmr_r;
    logic [MAG_W-1:0]  mag_w, mag_c;
    logic [SP_W-1:0]   sp_val;
    logic [SP_W-1:0]   sp_r [NCH];

    assign rx7           = rx_data[6:0];
    assign unused_rx_msb = rx_data[7];
    assign take          = rx_ready & ~clr_prev_r & RESET_N;
    assign rx_clear      = take;
    assign byte_to_err   = ~take & (state_r != ST_IDLE) & (state_r != ST_APPLY) & (tmr_r == '0);

    // Priority ID match: isolate the lowest matching channel index.
    always_comb begin
        id_match = '0;
        for (int k = 0; k < NCH; k++) begin
            id_match[k] = (rx7 == CH_IDS[k*8 +: 7]);
        end
        is_all  = (rx7 == ID_ALL[6:0]);
        id_mask = is_all ? {NCH{1'b1}} : (id_match & (~id_match + NCH'(1'b1)));
        id_hit  = is_all | (|id_match);
    end

    // Clamp the magnitude and apply the direction.
    always_comb begin
        mag_w = MAG_W'(mag_r);
        mag_c = (mag_w > MAX_MAG) ? MAX_MAG : mag_w;
        case (dir_r)
            DIR_FWD: sp_val = {1'b0, mag_c};
            DIR_REV: sp_val = ~{1'b0, mag_c} + SP_W'(1'b1);
            default: sp_val = '0;
        endcase
    end

    // Frame FSM next state, error and apply decisions.
    always_comb begin
        state_nx = state_r;
        fsm_err  = 1'b0;
        do_apply = 1'b0;
        if (take) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx7 == START_BYTE) state_nx = ST_GET_ID;
                    else                   state_nx = ST_IDLE;
                end
                ST_GET_ID: begin
                    if (rx7 == START_BYTE) begin
                        state_nx = ST_GET_ID;
                        fsm_err  = 1'b1;
                    end else if (id_hit) begin
                        state_nx = ST_GET_DIR;
                    end else begin
                        state_nx = ST_IDLE;
                        fsm_err  = 1'b1;
                    end
                end
                ST_GET_DIR: begin
                    if (rx7 == START_BYTE) begin
                        state_nx = ST_GET_ID;
                        fsm_err  = 1'b1;
                    end else if ((rx7 == DIR_FWD) || (rx7 == DIR_REV) || (rx7 == DIR_STOP)) begin
                        state_nx = ST_GET_MAG;
                    end else begin
                        state_nx = ST_IDLE;
                        fsm_err  = 1'b1;
                    end
                end
                ST_GET_MAG: state_nx = ST_GET_CHK;
                ST_GET_CHK: begin
                    if (rx7 == cmd_chk(id_r, dir_r, mag_r)) begin
                        state_nx = ST_APPLY;
                        do_apply = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                        fsm_err  = 1'b1;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end else if ((state_r == ST_APPLY) || byte_to_err) begin
            state_nx = ST_IDLE;
        end else begin
            state_nx = state_r;
        end
    end

    // FSM state, handshake history and frame field capture.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (!RESET_N) begin
            state_r    <= ST_IDLE;
            clr_prev_r <= 1'b0;
            id_r       <= 7'd0;
            dir_r      <= 7'd0;
            mag_r      <= 7'd0;
            mask_r     <= '0;
        end else begin
            state_r    <= state_nx;
            clr_prev_r <= take;
            if (take && (state_r == ST_GET_ID)) begin
                id_r   <= rx7;
                mask_r <= id_mask;
            end
            if (take && (state_r == ST_GET_DIR)) dir_r <= rx7;
            if (take && (state_r == ST_GET_MAG)) mag_r <= rx7;
        end
    end

    // Inter-byte timer and saturating error counter.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (!RESET_N) begin
            tmr_r     <= '0;
            err_count <= 8'd0;
        end else begin
            if (take)              tmr_r <= TW'(BYTE_TO - 1);
            else if (tmr_r != '0)  tmr_r <= tmr_r - TW'(1'b1);
            else                   tmr_r <= tmr_r;
            if ((fsm_err || byte_to_err) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end

    // Setpoint registers and update pulses, written as the CHK byte is accepted.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (!RESET_N) begin
            sp_update <= '0;
            for (int k = 0; k < NCH; k++) sp_r[k] <= '0;
        end else begin
            sp_update <= do_apply ? mask_r : '0;
            for (int k = 0; k < NCH; k++) begin
                if (do_apply && mask_r[k]) sp_r[k] <= sp_val;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        cmd_watchdog #(.WDT_CYC(WDT_CYC)) u_wdt (
            .clk     (FPGA_CLK1_50),
            .rst_n   (RESET_N),
            .kick    (do_apply & mask_r[k]),
            .expired (expired[k])
        );
        assign setpoint[k*SP_W +: SP_W] = expired[k] ? {SP_W{1'b0}} : sp_r[k];
    end

    assign sp_stale = expired;

endmodule

// File: tb/tb_motion_cmd_parser.sv
// Directed bench for motion_cmd_parser with a scoreboard of expected setpoint updates.
`timescale 1ns/1ps
module tb_motion_cmd_parser;

    typedef struct packed {
        logic [5:0]  mask;
        logic [47:0] sp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_clear;
    logic [47:0] setpoint;
    logic [5:0]  sp_update, sp_stale;
    logic [7:0]  err_count;

    int   n_vec = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [47:0] mon_bits;
    logic watch_stale = 1'b0;
    logic saw_stale = 1'b0;
    logic exp_clr;
    logic [7:0] id_tab [6] = '{8'h4C, 8'h52, 8'h41, 8'h42, 8'h43, 8'h44};

    always #5 clk = ~clk;

    motion_cmd_parser #(
        .NCH(6), .MAG_W(7), .CH_IDS("DCBARL"), .ID_ALL(8'h2A),
        .MAX_MAG(7'd100), .WDT_CYC(1000), .BYTE_TO(50)
    ) dut (
        .FPGA_CLK1_50(clk), .RESET_N(rst_n), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_clear(rx_clear), .setpoint(setpoint), .sp_update(sp_update),
        .sp_stale(sp_stale), .err_count(err_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_sp(input logic [7:0] dir, input logic [7:0] mag);
        logic [7:0] m;
        m = mag & 8'h7F;
        if (m > 8'd100) m = 8'd100;
        if (dir == 8'h2B) return m;
        if (dir == 8'h2D) return 8'h00 - m;
        return 8'h00;
    endfunction

    function automatic logic [7:0] chk_of(input logic [7:0] id, input logic [7:0] dir, input logic [7:0] mag);
        return (id ^ dir ^ mag) & 8'h7F;
    endfunction

    // Present one byte and wait (bounded) for the DUT to take it.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        rx_data  = b;
        rx_ready = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (rx_clear) got = 1'b1;
        end
        if (!got) check("byte_take_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic finish_frame(input logic [7:0] id, input logic [7:0] dir, input logic [7:0] mag);
        exp_t e;
        e = '0;
        for (int k = 0; k < 6; k++) begin
            if (id == 8'h2A || id == id_tab[k]) begin
                e.mask[k] = 1'b1;
                e.sp[k*8 +: 8] = exp_sp(dir, mag);
            end
        end
        send_byte(id);
        send_byte(dir);
        send_byte(mag);
        sb_q.push_back(e);
        send_byte(chk_of(id, dir, mag));
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [7:0] dir, input logic [7:0] mag);
        send_byte(8'h23);
        finish_frame(id, dir, mag);
    endtask

    // Scoreboard: every update pulse must match the oldest pending frame.
    always @(negedge clk) begin
        if (rst_n && sp_update !== 6'b0) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_update", {58'd0, sp_update}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                for (int k = 0; k < 6; k++) mon_bits[k*8 +: 8] = {8{mon_e.mask[k]}};
                check("sb_mask", {58'd0, sp_update}, {58'd0, mon_e.mask});
                check("sb_setpoint", {16'd0, setpoint & mon_bits}, {16'd0, mon_e.sp & mon_bits});
            end
        end
        if (watch_stale && sp_stale[1]) saw_stale = 1'b1;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_setpoint", {16'd0, setpoint}, 64'd0);
        check("rst_update", {58'd0, sp_update}, 64'd0);
        check("rst_stale", {58'd0, sp_stale}, 64'h3F);
        check("rst_err", {56'd0, err_count}, 64'd0);
        check("rst_rx_clear", {63'd0, rx_clear}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single channel forward command
        send_frame(8'h4C, 8'h2B, 8'h32);
        check("t1_update", {58'd0, sp_update}, 64'h01);
        check("t1_sp0", {56'd0, setpoint[7:0]}, 64'h32);
        check("t1_others", {24'd0, setpoint[47:8]}, 64'd0);
        @(posedge clk);
        #1;
        check("t1_pulse_end", {58'd0, sp_update}, 64'd0);
        check("t1_sp0_hold", {56'd0, setpoint[7:0]}, 64'h32);

        // Broadcast reverse with clamp
        send_frame(8'h2A, 8'h2D, 8'h7F);
        check("t2_update", {58'd0, sp_update}, 64'h3F);
        check("t2_all", {16'd0, setpoint}, {16'd0, {6{8'h9C}}});
        @(posedge clk);
        #1;
        check("t2_pulse_end", {58'd0, sp_update}, 64'd0);

        // Bad checksum, unknown ID, resync '#'
        send_byte(8'h23); send_byte(8'h4C); send_byte(8'h2B); send_byte(8'h10);
        send_byte(chk_of(8'h4C, 8'h2B, 8'h10) ^ 8'h01);
        check("t3_err_chk", {56'd0, err_count}, 64'd1);
        send_byte(8'h23); send_byte(8'h5A);
        check("t3_err_id", {56'd0, err_count}, 64'd2);
        send_byte(8'h23); send_byte(8'h41); send_byte(8'h23);
        check("t3_err_resync", {56'd0, err_count}, 64'd3);
        check("t3_unchanged", {16'd0, setpoint}, {16'd0, {6{8'h9C}}});
        finish_frame(8'h41, 8'h2B, 8'h05);
        check("t3_sp2", {56'd0, setpoint[23:16]}, 64'h05);
        check("t3_err_after", {56'd0, err_count}, 64'd3);

        // Inter-byte timeout
        send_byte(8'h23); send_byte(8'h52);
        repeat (51) @(posedge clk);
        #1;
        check("t4_err_to", {56'd0, err_count}, 64'd4);
        send_frame(8'h52, 8'h2B, 8'h14);
        check("t4_sp1", {56'd0, setpoint[15:8]}, 64'h14);
        check("t4_err_after", {56'd0, err_count}, 64'd4);

        // Watchdog expiry on channel 1
        repeat (999) @(posedge clk);
        #1;
        check("t5_not_stale", {63'd0, sp_stale[1]}, 64'd0);
        check("t5_sp1_live", {56'd0, setpoint[15:8]}, 64'h14);
        @(posedge clk);
        #1;
        check("t5_stale", {63'd0, sp_stale[1]}, 64'd1);
        check("t5_sp1_zero", {56'd0, setpoint[15:8]}, 64'd0);
        send_frame(8'h52, 8'h2D, 8'h0A);
        check("t5_rekick", {56'd0, setpoint[15:8]}, 64'hF6);
        check("t5_stale_clr", {63'd0, sp_stale[1]}, 64'd0);
        // CHK of the next frame is taken exactly 1000 edges after this apply
        watch_stale = 1'b1;
        saw_stale = 1'b0;
        repeat (991) @(posedge clk);
        #1;
        send_frame(8'h52, 8'h2B, 8'h40);
        check("t5_coincide_sp", {56'd0, setpoint[15:8]}, 64'h40);
        @(posedge clk);
        #1;
        watch_stale = 1'b0;
        check("t5_coincide_stale", {63'd0, saw_stale}, 64'd0);

        // Reset mid-frame, rx_ready held high
        send_byte(8'h23); send_byte(8'h4C); send_byte(8'h2B); send_byte(8'h20);
        rst_n = 1'b0;
        rx_data = chk_of(8'h4C, 8'h2B, 8'h20);
        rx_ready = 1'b1;
        @(negedge clk);
        check("t6_clr_in_reset", {63'd0, rx_clear}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t6_setpoint", {16'd0, setpoint}, 64'd0);
        check("t6_update", {58'd0, sp_update}, 64'd0);
        check("t6_stale", {58'd0, sp_stale}, 64'h3F);
        check("t6_err", {56'd0, err_count}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_clr = (i % 2 == 0);
            check("t6_rx_clear", {63'd0, rx_clear}, {63'd0, exp_clr});
        end
        rx_ready = 1'b0;
        @(posedge clk);
        #1;
        check("t6_err_after", {56'd0, err_count}, 64'd0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            send_byte(8'h23);
            send_byte(8'h5A);
        end
        check("sat_err", {56'd0, err_count}, 64'hFF);

        // Stop command
        send_frame(8'h42, 8'h30, 8'h55);
        check("stop_update", {58'd0, sp_update}, 64'h08);
        check("stop_sp3", {56'd0, setpoint[31:24]}, 64'd0);
        check("stop_stale3", {63'd0, sp_stale[3]}, 64'd0);
        @(posedge clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
